// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller: rotates one-hot digit selects with a
// blanking guard between digits and swaps in newly loaded values only at frame boundaries.
module sevenseg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int SLOT_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    lz_suppress,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic                    load_ack,
  output logic [3:0]              digit_number,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    seg_blank,
  output logic                    dp_out,
  output logic                    frame_done
);

  localparam int IW   = $clog2(NUM_DIGITS);
  localparam int MAXC = (SLOT_CYCLES > BLANK_CYCLES) ? SLOT_CYCLES : BLANK_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BLANK = 2'd1;
  localparam logic [1:0] SHOW  = 2'd2;

  localparam logic [CW-1:0] SLOT_LAST  = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);

  logic [1:0]              state, nxt_state;
  logic [CW-1:0]           cnt, nxt_cnt;
  logic [IW-1:0]           idx, nxt_idx;
  logic [4*NUM_DIGITS-1:0] act_val, nxt_act_val, sh_val, nxt_sh_val;
  logic [NUM_DIGITS-1:0]   act_dp, nxt_act_dp, sh_dp, nxt_sh_dp;
  logic                    pending, nxt_pending, ack_n;
  logic                    frame_end, xfer, zero_hi;
  logic                    show_n, blank_n, dp_n, fd_n;
  logic [3:0]              num_n;
  logic [NUM_DIGITS-1:0]   sel_n;

  always_comb begin
    frame_end = (state == SHOW) && (cnt == SLOT_LAST) && (idx == LAST_IDX);
    xfer      = (state == IDLE) || frame_end;

    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_idx   = idx;
    if (!enable) begin
      nxt_state = IDLE;
      nxt_cnt   = '0;
      nxt_idx   = '0;
    end else begin
      case (state)
        IDLE: begin
          nxt_state = BLANK;
          nxt_cnt   = '0;
          nxt_idx   = '0;
        end
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            nxt_state = SHOW;
            nxt_cnt   = '0;
          end else nxt_cnt = cnt + CW'(1);
        end
        SHOW: begin
          if (cnt == SLOT_LAST) begin
            nxt_state = BLANK;
            nxt_cnt   = '0;
            nxt_idx   = (idx == LAST_IDX) ? '0 : idx + IW'(1);
          end else nxt_cnt = cnt + CW'(1);
        end
        default: begin
          nxt_state = IDLE;
          nxt_cnt   = '0;
          nxt_idx   = '0;
        end
      endcase
    end

    // A load landing on a transfer cycle bypasses the shadow and goes live directly.
    nxt_act_val = act_val;
    nxt_act_dp  = act_dp;
    nxt_sh_val  = sh_val;
    nxt_sh_dp   = sh_dp;
    nxt_pending = pending;
    ack_n       = 1'b0;
    if (xfer && load) begin
      nxt_act_val = value;
      nxt_act_dp  = dp_in;
      nxt_pending = 1'b0;
      ack_n       = 1'b1;
    end else if (xfer && pending) begin
      nxt_act_val = sh_val;
      nxt_act_dp  = sh_dp;
      nxt_pending = 1'b0;
      ack_n       = 1'b1;
    end else if (load) begin
      nxt_sh_val  = value;
      nxt_sh_dp   = dp_in;
      nxt_pending = 1'b1;
    end

    // Outputs are decoded from next-state values so the registered outputs line up
    // with the state they describe.
    show_n  = (nxt_state == SHOW);
    zero_hi = 1'b1;
    num_n   = 4'd0;
    dp_n    = 1'b0;
    sel_n   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i >= int'(nxt_idx) && nxt_act_val[4*i +: 4] != 4'd0) zero_hi = 1'b0;
      if (show_n && i == int'(nxt_idx)) begin
        num_n    = nxt_act_val[4*i +: 4];
        dp_n     = nxt_act_dp[i];
        sel_n[i] = 1'b1;
      end
    end
    blank_n = !show_n || (lz_suppress && (nxt_idx != '0) && zero_hi);
    fd_n    = show_n && (nxt_cnt == SLOT_LAST) && (nxt_idx == LAST_IDX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      idx          <= '0;
      act_val      <= '0;
      act_dp       <= '0;
      sh_val       <= '0;
      sh_dp        <= '0;
      pending      <= 1'b0;
      load_ack     <= 1'b0;
      digit_number <= 4'd0;
      digit_sel    <= '0;
      seg_blank    <= 1'b1;
      dp_out       <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      state        <= nxt_state;
      cnt          <= nxt_cnt;
      idx          <= nxt_idx;
      act_val      <= nxt_act_val;
      act_dp       <= nxt_act_dp;
      sh_val       <= nxt_sh_val;
      sh_dp        <= nxt_sh_dp;
      pending      <= nxt_pending;
      load_ack     <= ack_n;
      digit_number <= num_n;
      digit_sel    <= sel_n;
      seg_blank    <= blank_n;
      dp_out       <= dp_n;
      frame_done   <= fd_n;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Bench for sevenseg_scan_ctrl: scan-position reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_sevenseg_scan_ctrl;
  localparam int N     = 4;
  localparam int SLOT  = 4;
  localparam int BLNK  = 2;
  localparam int PER   = SLOT + BLNK;
  localparam int FRAME = N * PER;

  logic clk = 1'b0;
  logic rst, enable, lz_suppress, load;
  logic [4*N-1:0] value;
  logic [N-1:0]   dp_in;
  logic           load_ack, seg_blank, dp_out, frame_done;
  logic [3:0]     digit_number;
  logic [N-1:0]   digit_sel;

  sevenseg_scan_ctrl #(.NUM_DIGITS(N), .SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLNK)) dut (
    .clk(clk), .rst(rst), .enable(enable), .lz_suppress(lz_suppress), .load(load),
    .value(value), .dp_in(dp_in), .load_ack(load_ack), .digit_number(digit_number),
    .digit_sel(digit_sel), .seg_blank(seg_blank), .dp_out(dp_out), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: m_t is the position within the frame since scanning started.
  bit          m_run, m_pend, m_ack, m_lz, m_valid;
  int          m_t;
  logic [15:0] m_act, m_sh;
  logic [3:0]  m_adp, m_sdp;

  always @(posedge clk) begin
    bit fe, xf;
    fe = m_run && (m_t % FRAME == FRAME - 1);
    xf = !m_run || fe;
    m_valid = 1'b1;
    if (rst) begin
      m_run = 0; m_t = 0; m_pend = 0; m_ack = 0; m_lz = 0;
      m_act = '0; m_sh = '0; m_adp = '0; m_sdp = '0;
    end else begin
      m_ack = 0;
      if (xf && load) begin
        m_act = value; m_adp = dp_in; m_pend = 0; m_ack = 1;
      end else if (xf && m_pend) begin
        m_act = m_sh; m_adp = m_sdp; m_pend = 0; m_ack = 1;
      end else if (load) begin
        m_sh = value; m_sdp = dp_in; m_pend = 1;
      end
      if (!enable) m_run = 0;
      else if (!m_run) begin m_run = 1; m_t = 0; end
      else m_t = (m_t + 1) % FRAME;
      m_lz = lz_suppress;
    end
  end

  always @(negedge clk) begin
    int d;
    bit show, fd, e_blank, e_dp;
    logic [3:0]  e_num;
    logic [N-1:0] e_sel;
    logic [15:0] hi;
    if (m_valid) begin
      show = 0; fd = 0; d = 0;
      if (m_run) begin
        d    = m_t / PER;
        show = (m_t % PER) >= BLNK;
        fd   = (m_t == FRAME - 1);
      end
      e_sel = '0; e_num = 4'd0; e_dp = 0; e_blank = 1;
      if (show) begin
        hi       = m_act >> (4 * d);
        e_sel[d] = 1'b1;
        e_num    = hi[3:0];
        e_dp     = m_adp[d];
        e_blank  = m_lz && (d > 0) && (hi == 16'd0);
      end
      chk("model_sel", digit_sel, e_sel);
      chk("model_num", digit_number, e_num);
      chk("model_blank", seg_blank, e_blank);
      chk("model_dp", dp_out, e_dp);
      chk("model_frame_done", frame_done, fd);
      chk("model_load_ack", load_ack, m_ack);
    end
  end

  int tcur;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic adv(input int target);
    step(target - tcur);
    tcur = target;
  endtask

  task automatic restart(input logic [15:0] v);
    enable = 0;
    step(1);
    value = v; dp_in = '0; load = 1; enable = 1;
    step(1);
    load = 0;
    tcur = 0;
  endtask

  initial begin
    int nack;
    rst = 1; enable = 0; lz_suppress = 0; load = 0; value = '0; dp_in = '0;
    step(3);
    chk("rst_sel", digit_sel, 0);
    chk("rst_num", digit_number, 0);
    chk("rst_blank", seg_blank, 1);
    chk("rst_dp", dp_out, 0);
    chk("rst_ack", load_ack, 0);
    chk("rst_fd", frame_done, 0);

    // Load through the IDLE path together with enable.
    rst = 0; load = 1; value = 16'h1234; dp_in = 4'b0101; enable = 1;
    step(1); tcur = 0; load = 0;
    chk("t1_ack", load_ack, 1);
    chk("t1_blank_t0", digit_sel, 0);
    adv(2);  chk("t1_sel0", digit_sel, 4'b0001); chk("t1_num0", digit_number, 4); chk("t1_dp0", dp_out, 1);
    adv(7);  chk("t1_guard", digit_sel, 0);
    adv(8);  chk("t1_sel1", digit_sel, 4'b0010); chk("t1_num1", digit_number, 3);
    adv(14); chk("t1_sel2", digit_sel, 4'b0100); chk("t1_num2", digit_number, 2);
    adv(20); chk("t1_sel3", digit_sel, 4'b1000); chk("t1_num3", digit_number, 1);
    adv(22); chk("t1_fd_early", frame_done, 0);
    adv(23); chk("t1_fd", frame_done, 1);
    adv(24); chk("t1_fd_pulse", frame_done, 0);
    adv(26); chk("t1_wrap", digit_sel, 4'b0001);

    // Leading-zero suppression.
    lz_suppress = 1;
    restart(16'h0070);
    adv(2);  chk("t2_d0_blank", seg_blank, 0); chk("t2_d0_num", digit_number, 0);
    adv(8);  chk("t2_d1_blank", seg_blank, 0); chk("t2_d1_num", digit_number, 7);
    adv(14); chk("t2_d2_blank", seg_blank, 1);
    adv(20); chk("t2_d3_blank", seg_blank, 1);
    restart(16'h0000);
    adv(2);  chk("t2z_d0_blank", seg_blank, 0); chk("t2z_d0_num", digit_number, 0);
    adv(8);  chk("t2z_d1_blank", seg_blank, 1);
    adv(20); chk("t2z_d3_blank", seg_blank, 1);

    // Mid-frame load applies only at the frame boundary.
    lz_suppress = 0;
    restart(16'h1234);
    adv(9);  load = 1; value = 16'h5678;
    adv(10); load = 0;
    adv(14); chk("t3_old2", digit_number, 2);
    adv(20); chk("t3_old1", digit_number, 1);
    adv(23); chk("t3_fd", frame_done, 1); chk("t3_no_ack_yet", load_ack, 0);
    adv(24); chk("t3_ack", load_ack, 1);
    adv(26); chk("t3_new0", digit_number, 8);

    // Two loads in one frame: last wins, single ack.
    adv(27); load = 1; value = 16'hAAAA;
    adv(28); load = 0;
    adv(30); load = 1; value = 16'h0042;
    adv(31); load = 0;
    nack = 0;
    for (int k = 31; k <= 50; k++) begin
      adv(k);
      if (load_ack === 1'b1) nack++;
    end
    chk("t4_one_ack", nack, 1);
    chk("t4_d0", digit_number, 2);
    adv(56); chk("t4_d1", digit_number, 4);
    adv(62); chk("t4_d2", digit_number, 0); chk("t4_d2_sel", digit_sel, 4'b0100);

    // Enable drop mid-SHOW, then resume from digit 0.
    enable = 0;
    step(1);
    chk("t5_dark_sel", digit_sel, 0); chk("t5_dark_blank", seg_blank, 1);
    enable = 1;
    step(1); tcur = 0;
    chk("t5_restart_blank", digit_sel, 0);
    adv(2); chk("t5_sel0", digit_sel, 4'b0001); chk("t5_num0", digit_number, 2);

    // Reset with a load pending.
    adv(5); load = 1; value = 16'h9999;
    step(1); load = 0; rst = 1;
    step(1);
    chk("t6_sel", digit_sel, 0); chk("t6_num", digit_number, 0);
    chk("t6_blank", seg_blank, 1); chk("t6_ack", load_ack, 0);
    rst = 0; lz_suppress = 1;
    step(1); tcur = 0;
    chk("t6_no_ack", load_ack, 0);
    adv(2); chk("t6_num0", digit_number, 0); chk("t6_blank0", seg_blank, 0);
    adv(8); chk("t6_blank1", seg_blank, 1);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      rst    = ($urandom_range(0, 999) == 0);
      enable = ($urandom_range(0, 199) != 0);
      load   = ($urandom_range(0, 29) == 0);
      value  = ($urandom_range(0, 2) == 0) ? (16'($urandom) & 16'h00FF) : 16'($urandom);
      dp_in  = 4'($urandom);
      if ($urandom_range(0, 49) == 0) lz_suppress = ~lz_suppress;
      step(1);
    end
    rst = 0; load = 0;
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sevenseg_scan_ctrl.md
Name: sevenseg_scan_ctrl

Overview:
Time-multiplexing scan controller for a bank of NUM_DIGITS common-select 7-segment digits that share one BCD-to-segment decoder. It cycles the digit selects, presents each digit's BCD nibble to the shared decoder, and inserts a blanking guard between digits to prevent ghosting. A shadow-register load handshake updates the displayed value only at a frame boundary, so no frame ever mixes old and new digits. Sits between a numeric producer (counter, timer, debug register) and the board-level decoder and digit drivers.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8); digit 0 is least significant.
SLOT_CYCLES, 50000, clock cycles a digit is driven (SHOW phase) per slot (>=1).
BLANK_CYCLES, 16, clock cycles all selects are off before each SHOW phase (>=1).

Ports:
clk  in  1  system clock.
rst  in  1  synchronous active-high reset.
enable  in  1  1 = scanning; 0 = display dark, scan halted.
lz_suppress  in  1  1 = blank leading zeros; digit 0 is never suppressed.
load  in  1  single-cycle request to capture value/dp_in.
value  in  4*NUM_DIGITS  BCD nibbles; digit i = value[4i+3:4i].
dp_in  in  NUM_DIGITS  decimal-point request per digit.
load_ack  out  1  one-cycle pulse: the captured value became active.
digit_number  out  4  BCD nibble to the shared decoder.
digit_sel  out  NUM_DIGITS  one-hot active-high digit enable; all-zero when dark.
seg_blank  out  1  1 = force segments off (suppressed digit or not in SHOW).
dp_out  out  1  decimal point for the current digit.
frame_done  out  1  one-cycle pulse when the last digit's slot ends.

Behaviour:
- Reset: state=IDLE, digit index=0, counters=0, active and shadow registers=0, pending=0; digit_sel=0, digit_number=0, seg_blank=1, dp_out=0, load_ack=0, frame_done=0. All outputs registered.
- Clocking and reset: one clock; reset is synchronous and active-high.
- States:
  - IDLE: entered on reset or when enable=0 (from any state, next cycle). Outputs are dark (digit_sel=0, seg_blank=1). If enable=1, go to BLANK with index 0.
  - BLANK: digit_sel=0 and seg_blank=1 for exactly BLANK_CYCLES cycles, then go to SHOW.
  - SHOW: for exactly SLOT_CYCLES cycles, digit_sel = 1<<index, digit_number = active nibble[index], dp_out = active dp[index], and seg_blank = suppress(index). At the end of SHOW, if index=NUM_DIGITS-1 then index becomes 0 and frame_done pulses on that cycle; otherwise index increments. Then go to BLANK.
- Slot timing: digit period = BLANK_CYCLES+SLOT_CYCLES. Frame period = NUM_DIGITS*(BLANK_CYCLES+SLOT_CYCLES).
- Leading-zero suppression: suppress(i)=1 when lz_suppress=1, i>0, and active nibbles i..NUM_DIGITS-1 are all 0. dp_out is still driven for a suppressed digit.
- Nibbles 10..15 are passed through unchanged; the decoder handles them as its default.
- Load handshake:
  - load=1 copies value/dp_in into the shadow register and sets pending=1. A later load before the boundary overwrites the shadow (last write wins).
  - At a frame boundary (the frame_done cycle), or on any cycle in IDLE, a pending shadow is copied to active, pending is cleared, and load_ack pulses on the following cycle.
  - If load and the frame_done cycle coincide, the new value goes straight to active and load_ack pulses next cycle.
- enable falling mid-slot: abort the slot and go to IDLE; index resets to 0. Active and pending values are retained.
- Reset mid-operation overrides everything, including a pending load; no load_ack is issued.

Test Plan:
1. With NUM_DIGITS=4, SLOT_CYCLES=4, BLANK_CYCLES=2: reset, then load value=16'h1234, enable=1 -> load_ack pulses within 2 cycles (IDLE path). digit_sel sequence is 0001, 0010, 0100, 1000 with digit_number 4, 3, 2, 1. Each digit is shown for 4 cycles with 2 dark cycles before it, and frame_done pulses every 24 cycles.
2. lz_suppress=1, value=16'h0070 -> seg_blank=1 for digits 3 and 2, 0 for digits 1 and 0. Then value=16'h0000 -> only digit 0 is unblanked, showing 0.
3. Mid-frame load of 16'h5678 during digit 1 -> the rest of the frame still shows 1234. At the frame_done cycle active becomes 5678, load_ack pulses the next cycle, and digit 0 of the next frame shows 8.
4. Two loads in one frame (16'hAAAA, then 16'h0042) -> only 0042 is displayed, and exactly one load_ack is issued.
5. Drop enable during SHOW of digit 2 -> digit_sel=0 and seg_blank=1 on the next cycle. Re-enabling restarts at BLANK, digit 0, still showing the previously active value.
6. Assert rst with a load pending -> all outputs return to reset values, no load_ack, and digit_number=0.
